// File: rtl/instr_prefetch_buffer_pkg.sv
// Fetch-side shared types: prefetch entry layout, prefetch FSM states, instruction size.
package cpu_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } pf_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pf_state_t;
endpackage

// File: rtl/instr_prefetch_buffer_if.sv
// Instruction-memory port: req/addr held until gnt, rvalid/rdata return in issue order.
interface instr_prefetch_buffer_if #(
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [AW-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_prefetch_buffer_pf_fifo.sv
// Circular store of PC-tagged prefetched words; head is visible combinationally.
// Zero-latency head read; push and pop may share a cycle even when full, flush empties in one cycle.
module pf_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [XLEN-1:0]          push_instr,
    input  logic                     pop,
    output pf_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pf_entry_t     slot_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;

    assign head = slot_q[head_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i].valid <= 1'b0;
            head_q <= '0;
            tail_q <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                slot_q[head_q].valid <= 1'b0;
                head_q               <= head_q + 1'b1;
            end
            // When full, head and tail alias: the push write must win over the pop clear.
            if (push) begin
                slot_q[tail_q] <= '{valid: 1'b1, pc: push_pc, instr: push_instr};
                tail_q         <= tail_q + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/instr_prefetch_buffer.sv
// Prefetches sequential words ahead of PCF and serves InstrF on a tag hit; flushes on redirect.
// Hit is combinational from the head (2 cycles after issue at memory latency 1); buffered + outstanding never exceeds DEPTH.
module instr_prefetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = XLEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [AW-1:0]           PCF,
    input  logic                    StallF,
    output logic [AW-1:0]           InstrF,
    output logic                    InstrHitF,
    output logic                    BufStallF,
    instr_prefetch_buffer_if.master imem
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] STEP    = AW'(INSTR_BYTES);

    pf_state_t     state_q, state_d;
    logic [AW-1:0] pf_ptr_q, tail_pc_q;
    logic [CW-1:0] inflight_q, drop_cnt_q, drop_cnt_d, occupancy;
    pf_entry_t     head;
    logic          mismatch, req, issue, push, pop;

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .flush      (mismatch),
        .push       (push),
        .push_pc    (tail_pc_q),
        .push_instr (imem.imem_rdata),
        .pop        (pop),
        .head       (head),
        .count      (occupancy)
    );

    assign InstrHitF      = head.valid && (head.pc == PCF);
    assign InstrF         = InstrHitF ? head.instr : '0;
    assign BufStallF      = ~InstrHitF;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pf_ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = RUN;
            RUN, DRAIN: state_d = (drop_cnt_d != '0) ? DRAIN : RUN;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        mismatch = 1'b0;
        req      = 1'b0;
        if (state_q != IDLE) begin
            // An empty, quiet buffer whose next tag disagrees with PCF is a redirect too.
            mismatch = (head.valid && (head.pc != PCF)) ||
                       ((occupancy == '0) && (inflight_q == '0) && (PCF != tail_pc_q));
            req      = !mismatch && ((occupancy + inflight_q) < DEPTH_C);
        end
        issue = req && imem.imem_gnt;
        pop   = InstrHitF && !StallF;
        push  = imem.imem_rvalid && !mismatch && (drop_cnt_q == '0) && (state_q != IDLE);
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (mismatch)
            drop_cnt_d = inflight_q + CW'(issue) - CW'(imem.imem_rvalid);
        else if (imem.imem_rvalid && (drop_cnt_q != '0))
            drop_cnt_d = drop_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pf_ptr_q   <= '0;
            tail_pc_q  <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(issue) - CW'(imem.imem_rvalid);
            drop_cnt_q <= drop_cnt_d;
            if ((state_q == IDLE) || mismatch) begin
                pf_ptr_q  <= PCF;
                tail_pc_q <= PCF;
            end else begin
                if (issue) pf_ptr_q  <= pf_ptr_q + STEP;
                if (push)  tail_pc_q <= tail_pc_q + STEP;
            end
        end
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: queue-based fetch model, latency/grant memory model, directed scenarios.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] PCF    = '0;
    logic        StallF = 1'b1;
    logic [31:0] InstrF;
    logic        InstrHitF, BufStallF;

    instr_prefetch_buffer_if #(.AW(32)) imem ();

    instr_prefetch_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .PCF       (PCF),
        .StallF    (StallF),
        .InstrF    (InstrF),
        .InstrHitF (InstrHitF),
        .BufStallF (BufStallF),
        .imem      (imem)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h1000_0001 + a * 32'd3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Fetch model: buffered PCs in order, outstanding requests tagged live/stale.
    typedef struct {
        logic [31:0] addr;
        bit          live;
    } oreq_t;
    logic [31:0] bq[$];
    oreq_t       oq[$];
    bit          m_active = 0;
    logic [31:0] m_pf     = '0;
    bit          exp_hit, exp_req, exp_mis;
    logic [31:0] exp_instr, exp_addr;

    // Memory model: in-order responses, each at least its latency after issue.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    last_due = 0;
    int    lat_min  = 1;
    int    lat_max  = 1;
    bit    gnt_rand = 0;
    bit    gnt_v    = 1;

    logic [31:0] pc_q = '0;
    int          hold = 0;
    bit          cmp_on = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = '0;

    task automatic drive();
        PCF       = pc_q;
        exp_hit   = (bq.size() > 0) && (bq[0] == pc_q);
        exp_mis   = m_active && (((bq.size() > 0) && (bq[0] != pc_q)) ||
                                 ((bq.size() == 0) && (oq.size() == 0) && (pc_q != m_pf)));
        exp_req   = m_active && !exp_mis && ((bq.size() + oq.size()) < DEPTH);
        exp_addr  = m_pf;
        exp_instr = exp_hit ? mem_f(pc_q) : 32'h0;
        StallF    = !exp_hit || (hold > 0);
        imem.imem_gnt    = gnt_v;
        imem.imem_rvalid = reset && (mq.size() > 0) && (mq[0].due <= cyc);
        imem.imem_rdata  = imem.imem_rvalid ? mem_f(mq[0].addr) : 32'h0;
    endtask

    task automatic model_reset();
        m_active = 0;
        bq.delete();
        oq.delete();
        m_pf     = '0;
        pc_q     = '0;
        hold     = 0;
        mq.delete();
        last_due = 0;
    endtask

    task automatic tick();
        bit          rv, gn, stl, iss, hit, req, mis;
        logic [31:0] pcv, iaddr;
        oreq_t       r;
        mreq_t       m;
        @(negedge clk);
        rv = imem.imem_rvalid; gn = imem.imem_gnt; stl = StallF; pcv = PCF;
        hit = exp_hit; req = exp_req; mis = exp_mis;
        iss = reset && imem.imem_req && imem.imem_gnt;
        iaddr = imem.imem_addr;
        @(posedge clk);
        if (reset) begin
            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (iss) begin
                m.addr = iaddr;
                m.due  = cyc + $urandom_range(lat_min, lat_max);
                if (m.due <= last_due) m.due = last_due + 1;
                last_due = m.due;
                mq.push_back(m);
            end
            if (!m_active) begin
                m_active = 1;
                m_pf     = pcv;
            end else begin
                if (rv && oq.size() > 0) begin
                    r = oq.pop_front();
                    if (r.live && !mis) bq.push_back(r.addr);
                end
                if (mis) begin
                    bq.delete();
                    foreach (oq[i]) oq[i].live = 0;
                    m_pf = pcv;
                end else begin
                    if (hit && !stl) void'(bq.pop_front());
                    if (req && gn) begin
                        r.addr = m_pf;
                        r.live = 1;
                        oq.push_back(r);
                        m_pf = m_pf + 32'd4;
                    end
                end
            end
            if (!stl) pc_q = pc_q + 32'd4;
            if (hold > 0) hold--;
        end
        cyc++;
        #1;
        gnt_v = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        drive();
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("InstrHitF", InstrHitF, exp_hit);
            chk("InstrF", InstrF, exp_instr);
            chk("BufStallF", BufStallF, !exp_hit);
            chk("imem_req", imem.imem_req, exp_req);
            chk("imem_addr", imem.imem_addr, exp_addr);
            if (InstrHitF) chk("hit_data_matches_mem", InstrF, mem_f(PCF));
            chk("outstanding_le_depth", mq.size() <= DEPTH, 1'b1);
            if (reset && pend && !exp_mis) begin
                chk("req_held_until_gnt", imem.imem_req, 1'b1);
                chk("addr_held_until_gnt", imem.imem_addr, pend_addr);
            end
            pend      = reset && imem.imem_req && !imem.imem_gnt && !exp_mis;
            pend_addr = imem.imem_addr;
        end
    end

    task automatic run_until_pc(input logic [31:0] target);
        for (int i = 0; i < 60 && pc_q != target; i++) tick();
        if (pc_q != target) chk("reach_pc_timeout", PCF, target);
    endtask

    task automatic wait_hit(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_ins);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            #2;
            if (InstrHitF) begin
                seen = 1;
                chk({name, "_pc"}, PCF, exp_pc);
                chk({name, "_instr"}, InstrF, exp_ins);
            end
        end
        if (!seen) chk({name, "_timeout"}, InstrHitF, 1'b1);
    endtask

    task automatic restart_checks(input string name);
        logic [31:0] addrs [4];
        addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int c = 1; c <= 4; c++) begin
            tick();
            #2;
            chk({name, "_req"}, imem.imem_req, 1'b1);
            chk({name, "_addr"}, imem.imem_addr, addrs[c-1]);
            if (c == 3) begin
                chk({name, "_first_hit"}, InstrHitF, 1'b1);
                chk({name, "_first_instr"}, InstrF, 32'h1000_0001);
            end
        end
    endtask

    initial begin
        model_reset();
        drive();
        cmp_on = 1;
        tick();
        tick();
        #1;
        chk("reset_req", imem.imem_req, 1'b0);
        chk("reset_stall", BufStallF, 1'b1);
        reset = 1'b1;
        cyc   = 0;
        drive();
        restart_checks("startup");

        // Hazard stall at 0x10: buffer fills and the request drops.
        run_until_pc(32'h10);
        hold = 3;
        drive();
        tick();
        tick();
        #2;
        chk("stall_req_dropped", imem.imem_req, 1'b0);
        chk("stall_instr_held", InstrF, 32'h1000_0031);
        tick();
        #2;
        chk("release_hit0", InstrHitF, 1'b1);
        tick();
        #2;
        chk("release_hit1", InstrHitF, 1'b1);
        chk("release_instr1", InstrF, 32'h1000_003D);

        // Branch with several requests in flight.
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 8; i++) tick();
        pc_q = 32'h80;
        drive();
        wait_hit("branch_80", 32'h80, 32'h1000_0181);
        for (int i = 0; i < 3; i++) tick();
        pc_q = 32'hC0;
        drive();
        tick();
        pc_q = 32'h100;
        drive();
        wait_hit("branch_100", 32'h100, 32'h1000_0301);

        // Fill completely, flush, then redirect again while empty and quiet.
        lat_min = 1;
        lat_max = 1;
        hold = 4;
        drive();
        for (int i = 0; i < 4; i++) tick();
        pc_q = 32'h40;
        drive();
        tick();
        pc_q = 32'h200;
        drive();
        wait_hit("empty_redirect", 32'h200, 32'h1000_0601);

        // Variable latency with grant back-pressure, random redirects and stalls.
        lat_max  = 5;
        gnt_rand = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(0, 24) == 0) begin
                pc_q = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
                drive();
            end else if (hold == 0 && $urandom_range(0, 9) == 0) begin
                hold = int'($urandom_range(1, 3));
                drive();
            end
        end

        // Reset in the middle of a stream with entries buffered.
        lat_max  = 1;
        gnt_rand = 0;
        for (int i = 0; i < 20; i++) tick();
        hold = 2;
        drive();
        tick();
        tick();
        #1;
        reset = 1'b0;
        model_reset();
        drive();
        #1;
        chk("midreset_req", imem.imem_req, 1'b0);
        chk("midreset_addr", imem.imem_addr, 32'h0);
        chk("midreset_hit", InstrHitF, 1'b0);
        chk("midreset_instr", InstrF, 32'h0);
        chk("midreset_stall", BufStallF, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        cyc   = 0;
        drive();
        restart_checks("restart");
        for (int i = 0; i < 10; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
